// File: rtl/mbo_stream_pkg.sv
// Shared constants for the ADC block stream: block geometry, header layout
// and the arbiter FSM encoding.
package mbo_stream_pkg;

    localparam int BLOCK_LEN  = 256;
    localparam int SEQ_W      = 12;

    localparam int HDR_CH_BIT = 15;
    localparam int HDR_RSV_HI = 14;
    localparam int HDR_RSV_LO = 12;
    localparam int HDR_SEQ_HI = 11;
    localparam int HDR_SEQ_W  = HDR_SEQ_HI + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    function automatic logic [15:0] make_hdr(input logic ch, input logic [HDR_SEQ_HI:0] seq);
        logic [15:0] h;
        h                        = '0;
        h[HDR_CH_BIT]            = ch;
        h[HDR_RSV_HI:HDR_RSV_LO] = '0;
        h[HDR_SEQ_HI:0]          = seq;
        return h;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. On a tie the channel that did not win
// last time is chosen; last-grant is only updated when a block completes.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_gnt,
    output logic       gnt,
    output logic       any
);

    logic last_q;
    logic last_d;

    always_comb begin
        last_d = last_q;
        if (upd) begin
            last_d = upd_gnt;
        end
    end

    // Reset to 1 so channel 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        any = |req;
        gnt = 1'b0;
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last_q;
            default: gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/adc_block_arbiter.sv
// Two-channel ADC block arbiter: grants a FIFO holding a full block and
// streams one header word followed by BLOCK_LEN data words.
//   state | meaning
//   IDLE  | waiting for en, tx_ready and a channel with a full block
//   HDR   | header word out, first FIFO read issued
//   DATA  | BLOCK_LEN data words; reads stop one cycle before the end
//   GAP   | sequence / block count / last-grant bookkeeping
module adc_block_arbiter #(
    parameter int BLOCK_LEN = mbo_stream_pkg::BLOCK_LEN,
    parameter int SEQ_W     = mbo_stream_pkg::SEQ_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        tx_ready,
    input  logic [1:0]  avail,
    input  logic [15:0] fifo_dout0,
    input  logic [15:0] fifo_dout1,
    output logic [1:0]  rd_en,
    output logic [15:0] dout,
    output logic        dout_valid,
    output logic        sof,
    output logic        eof,
    output logic        busy,
    output logic [15:0] blk_cnt
);
    import mbo_stream_pkg::*;

    localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLOCK_LEN - 1);

    state_e             state_q, state_d;
    logic               g_q, g_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEQ_W-1:0]   seq0_q, seq0_d;
    logic [SEQ_W-1:0]   seq1_q, seq1_d;
    logic [15:0]        blk_cnt_q, blk_cnt_d;
    logic [SEQ_W-1:0]   seq_g;
    logic               arb_gnt;
    logic               arb_any;
    logic               arb_upd;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (avail),
        .upd     (arb_upd),
        .upd_gnt (g_q),
        .gnt     (arb_gnt),
        .any     (arb_any)
    );

    assign seq_g = g_q ? seq1_q : seq0_q;

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        cnt_d      = cnt_q;
        seq0_d     = seq0_q;
        seq1_d     = seq1_q;
        blk_cnt_d  = blk_cnt_q;
        arb_upd    = 1'b0;
        rd_en      = 2'b00;
        dout       = 16'h0000;
        dout_valid = 1'b0;
        sof        = 1'b0;
        eof        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && tx_ready && arb_any) begin
                    g_d     = arb_gnt;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                dout       = make_hdr(g_q, HDR_SEQ_W'(seq_g));
                dout_valid = 1'b1;
                sof        = 1'b1;
                rd_en[g_q] = 1'b1;
                cnt_d      = CNT_LOAD;
                state_d    = ST_DATA;
            end
            ST_DATA: begin
                // FIFO data lags rd_en by one cycle, so the header read
                // supplies word 0 and the last data cycle needs no read.
                dout       = g_q ? fifo_dout1 : fifo_dout0;
                dout_valid = 1'b1;
                if (cnt_q == '0) begin
                    eof     = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    rd_en[g_q] = 1'b1;
                    cnt_d      = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (g_q) begin
                    seq1_d = seq1_q + SEQ_W'(1);
                end else begin
                    seq0_d = seq0_q + SEQ_W'(1);
                end
                if (blk_cnt_q != 16'hFFFF) begin
                    blk_cnt_d = blk_cnt_q + 16'd1;
                end
                arb_upd = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            g_q       <= 1'b0;
            cnt_q     <= '0;
            seq0_q    <= '0;
            seq1_q    <= '0;
            blk_cnt_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            cnt_q     <= cnt_d;
            seq0_q    <= seq0_d;
            seq1_q    <= seq1_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign blk_cnt = blk_cnt_q;

endmodule
